// File: rtl/ensm_ctrl.sv
// ensm_ctrl: AD9361 ENSM pin sequencer enforcing txnrx setup, minimum enable-on and txnrx hold.
// Define ENSM_TIMEOUT_EN to add a sticky watchdog on enable-high time.
module ensm_ctrl #(
    parameter int SETUP_CYCLES  = 4,
    parameter int HOLD_CYCLES   = 4,
    parameter int MIN_ON_CYCLES = 8,
    parameter int MAX_ON_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_enable,
    input  logic       req_txnrx,
    output logic       enable,
    output logic       txnrx,
    output logic       tx_active,
    output logic       rx_active,
    output logic       busy,
    output logic [1:0] state,
    output logic       timeout
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACTIVE = 2'd2, HOLD = 2'd3} state_t;

    localparam logic [CNT_WIDTH-1:0] L_SETUP = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] L_MIN   = CNT_WIDTH'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] L_HOLD  = CNT_WIDTH'(HOLD_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_en_sync, r_dir_sync;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 w_en_s, w_dir_s, w_dir_nxt, w_on_exp;

    assign w_en_s  = r_en_sync[1];
    assign w_dir_s = r_dir_sync[1];
    assign state   = r_state;

`ifdef ENSM_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] L_MAX = CNT_WIDTH'(MAX_ON_CYCLES - 1);
    logic [CNT_WIDTH-1:0] r_on;
    logic                 w_to_nxt;

    assign w_on_exp = (r_state == ACTIVE) && (r_on == L_MAX);

    // Watchdog counts clocks spent in ACTIVE and is cleared everywhere else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_on    <= '0;
            timeout <= 1'b0;
        end else begin
            r_on    <= (w_state_nxt == ACTIVE && r_state == ACTIVE) ? r_on + CNT_WIDTH'(1) : '0;
            timeout <= w_to_nxt;
        end
    end
`else
    assign w_on_exp = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = txnrx;
`ifdef ENSM_TIMEOUT_EN
        w_to_nxt    = timeout;
`endif
        case (r_state)
            IDLE: begin
                if (w_en_s && !timeout) begin
                    w_state_nxt = SETUP;
                    w_dir_nxt   = w_dir_s;
                    w_cnt_nxt   = L_SETUP;
                end
`ifdef ENSM_TIMEOUT_EN
                if (!w_en_s) w_to_nxt = 1'b0;
`endif
            end
            SETUP: begin
                if (!w_en_s) begin
                    w_state_nxt = IDLE;
                end else if (w_dir_s != txnrx) begin
                    w_dir_nxt = w_dir_s;
                    w_cnt_nxt = L_SETUP;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = L_MIN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ACTIVE: begin
                if (w_on_exp || (r_cnt == '0 && (!w_en_s || w_dir_s != txnrx))) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = L_HOLD;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
`ifdef ENSM_TIMEOUT_EN
                if (w_on_exp) w_to_nxt = 1'b1;
`endif
            end
            HOLD: begin
                if (r_cnt == '0) w_state_nxt = IDLE;
                else w_cnt_nxt = r_cnt - 1'b1;
            end
        endcase
    end

    // Flags are computed from the next state so they land on the same edge as enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_en_sync  <= '0;
            r_dir_sync <= '0;
            r_state    <= IDLE;
            r_cnt      <= '0;
            txnrx      <= 1'b0;
            enable     <= 1'b0;
            tx_active  <= 1'b0;
            rx_active  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_en_sync  <= {r_en_sync[0], req_enable};
            r_dir_sync <= {r_dir_sync[0], req_txnrx};
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            txnrx      <= w_dir_nxt;
            enable     <= w_state_nxt == ACTIVE;
            tx_active  <= (w_state_nxt == ACTIVE) && w_dir_nxt;
            rx_active  <= (w_state_nxt == ACTIVE) && !w_dir_nxt;
            busy       <= (w_state_nxt == SETUP) || (w_state_nxt == HOLD);
        end
    end
endmodule

// File: tb/tb_ensm_ctrl.sv
// tb_ensm_ctrl: directed timing scenarios plus randomized requests checked against a phase/age model.
module tb_ensm_ctrl;
    localparam int S  = 4;
    localparam int H  = 4;
    localparam int MN = 8;
    localparam int MX = 16;
`ifdef ENSM_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic       clk = 1'b0, rstn = 1'b0, req_enable = 1'b0, req_txnrx = 1'b0;
    logic       enable, txnrx, tx_active, rx_active, busy, timeout;
    logic [1:0] state;
    int         n_vec = 0, n_err = 0;

    logic m_e1, m_e2, m_d1, m_d2, m_dir, m_to;
    int   m_ph, m_age;

    always #5 clk = ~clk;

    ensm_ctrl #(
        .SETUP_CYCLES(S), .HOLD_CYCLES(H), .MIN_ON_CYCLES(MN),
        .MAX_ON_CYCLES(MX), .CNT_WIDTH(20)
    ) dut (
        .clk(clk), .rstn(rstn), .req_enable(req_enable), .req_txnrx(req_txnrx),
        .enable(enable), .txnrx(txnrx), .tx_active(tx_active), .rx_active(rx_active),
        .busy(busy), .state(state), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {24'd0, timeout, state, busy, rx_active, tx_active, txnrx, enable};
    endfunction

    function automatic logic [31:0] model_outs();
        logic on;
        on = (m_ph == 2);
        return {24'd0, m_to, 2'(m_ph), (m_ph == 1 || m_ph == 3), on && !m_dir, on && m_dir, m_dir, on};
    endfunction

    task automatic model_reset();
        {m_e1, m_e2, m_d1, m_d2, m_dir, m_to} = '0;
        m_ph  = 0;
        m_age = 0;
    endtask

    // Phase/age view: age is how many clocks have elapsed since entering the phase.
    task automatic model_edge();
        logic es, ds;
        es = m_e2;
        ds = m_d2;
        m_e2 = m_e1; m_e1 = req_enable;
        m_d2 = m_d1; m_d1 = req_txnrx;
        case (m_ph)
            0: if (es && !m_to) begin m_ph = 1; m_age = 0; m_dir = ds; end
               else if (!es) m_to = 1'b0;
            1: if (!es) m_ph = 0;
               else if (ds != m_dir) begin m_dir = ds; m_age = 0; end
               else if (m_age == S - 1) begin m_ph = 2; m_age = 0; end
               else m_age++;
            2: if (TO && m_age == MX - 1) begin m_ph = 3; m_age = 0; m_to = 1'b1; end
               else if (m_age >= MN - 1 && (!es || ds != m_dir)) begin m_ph = 3; m_age = 0; end
               else m_age++;
            default: if (m_age == H - 1) m_ph = 0; else m_age++;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("outs", dut_outs(), model_outs());
        chk("excl", {31'd0, tx_active & rx_active}, 32'd0);
    endtask

    task automatic async_reset();
        #2 rstn = 1'b0;
        #1 chk("async_rst", dut_outs(), 32'd0);
        model_reset();
        #1 rstn = 1'b1;
    endtask

    initial begin
        int n_en, n_hold, n_setup;
        logic prev_dir;
        model_reset();
        #12 chk("reset", dut_outs(), 32'd0);
        @(negedge clk) rstn = 1'b1;

        // Latency from request to enable, then minimum on-time and hold
        req_txnrx = 1'b1;
        repeat (4) tick();
        req_enable = 1'b1;
        n_en = 0;
        n_hold = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 3) chk("setup_txnrx", {30'd0, state, txnrx}, {30'd1, 1'b1});
            if (k <= 7) chk("busy_lat", {31'd0, busy}, {31'd0, k >= 3 && k <= 6});
            if (k <= 7) chk("en_lat", {30'd0, enable, tx_active}, {30'd0, k == 7, k == 7});
            if (k == 7) req_enable = 1'b0;
            n_en += enable;
            if (state == 2'd3 && txnrx) n_hold++;
        end
        chk("on_len", n_en, MN);
        chk("hold_len", n_hold, H);
        chk("end_idle", {30'd0, state}, 32'd0);

        // RX active, then flip to TX
        req_txnrx = 1'b0;
        req_enable = 1'b1;
        for (int i = 0; i < 40 && !enable; i++) tick();
        chk("rx_up", {30'd0, enable, rx_active}, 32'd3);
        req_txnrx = 1'b1;
        prev_dir = txnrx;
        n_hold = 0;
        n_setup = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("dir_while_en", {31'd0, enable && (txnrx != prev_dir)}, 32'd0);
            prev_dir = txnrx;
            if (state == 2'd3 && !txnrx) n_hold++;
            if (state == 2'd1 && txnrx) n_setup++;
        end
        chk("flip_hold", n_hold, H);
        chk("flip_setup", n_setup, S);
        chk("flip_tx", {30'd0, enable, tx_active}, 32'd3);

        // Drop request during SETUP: enable must never pulse
        req_enable = 1'b0;
        for (int i = 0; i < 40 && state != 2'd0; i++) tick();
        req_enable = 1'b1;
        for (int i = 0; i < 10 && state != 2'd1; i++) tick();
        chk("in_setup", {30'd0, state}, 32'd1);
        req_enable = 1'b0;
        n_en = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_en += enable;
        end
        chk("no_pulse", n_en, 0);
        chk("abort_idle", {30'd0, state}, 32'd0);

        // Reset while ACTIVE
        req_enable = 1'b1;
        for (int i = 0; i < 40 && !enable; i++) tick();
        chk("pre_rst_en", {31'd0, enable}, 32'd1);
        async_reset();
        repeat (3) tick();

`ifdef ENSM_TIMEOUT_EN
        req_enable = 1'b1;
        for (int i = 0; i < 40 && !enable; i++) tick();
        n_en = 0;
        n_setup = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            n_en += enable;
            if (timeout && state == 2'd1) n_setup++;
        end
        chk("to_len", n_en + 1, MX);
        chk("to_flag", {31'd0, timeout}, 32'd1);
        chk("to_no_rearm", n_setup, 0);
        req_enable = 1'b0;
        repeat (6) tick();
        chk("to_clear", {31'd0, timeout}, 32'd0);
`endif

        // Randomized requests with slow toggling so every phase is reached
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(15) == 0) req_enable = ~req_enable;
            if ($urandom_range(19) == 0) req_txnrx = ~req_txnrx;
            if ($urandom_range(599) == 0) async_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
